event_strobe_gen: RTL

- Upstream event producer for the event-driven consumer stages (`always @E` / `forever @E` style consumers).
- Takes one asynchronous level input, synchronises and debounces it, and classifies qualifying edges as rise or fall.
- Queues the classified edges in a small FIFO and presents them to the downstream consumer over a valid/ready handshake, one event per transfer.

---
 rtl/event_strobe_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/event_strobe_gen.sv
// Synchronises and debounces an asynchronous level, classifies accepted edges as
// rise/fall and queues them in a small FIFO presented over a valid/ready handshake.
module event_strobe_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 2,
    parameter int DEPTH           = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evt_in,
    input  logic                     enable,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_kind,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic             ALLOW_RISE = (EDGE_MODE != 1);
    localparam logic             ALLOW_FALL = (EDGE_MODE != 0);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_CHK,
        ST_HIGH,
        ST_FALL_CHK
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Stage p0: input synchroniser
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], evt_in};
        end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];

    // Stage p1: debounce FSM, edge strobes registered
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_d, fall_d;
    logic             rise_evt_p1, fall_evt_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOW;
            cnt_q       <= '0;
            rise_evt_p1 <= 1'b0;
            fall_evt_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rise_evt_p1 <= rise_d;
            fall_evt_p1 <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (s_p0) begin
                    state_d = ST_RISE_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_RISE_CHK: begin
                if (!s_p0) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_HIGH: begin
                if (!s_p0) begin
                    state_d = ST_FALL_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_FALL_CHK: begin
                if (s_p0) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LOW;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_LOW;
            end
        endcase
    end

    // Stage p2: qualification and event FIFO
    logic             push, pop, full, do_write;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             mem [DEPTH];

    assign push     = enable & ((rise_evt_p1 & ALLOW_RISE) | (fall_evt_p1 & ALLOW_FALL));
    assign evt_valid = (count != '0);
    assign pop      = evt_valid & evt_ready;
    assign full     = (count == FULL_CNT);
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_write = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_write, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= fall_evt_p1;
        end
    end

    assign evt_kind = evt_valid & mem[rd_ptr];
    assign pending  = count;

endmodule
